// File: rtl/load_store_completion_buffer_if.sv
// Handshake and CDB bundle between the LoadStore unit, the completion buffer and the CDB arbiters.
// The master modport is the buffer's own view; slave is the surrounding pipeline.
interface load_store_completion_buffer_if #(
  parameter int DEPTH_BITS = 2,
  parameter int CDB_COUNT  = 2,
  parameter int DATA_WIDTH = 32,
  parameter int RRN_WIDTH  = 6
);
  logic                            i_flush;
  logic                            i_in_valid;
  logic                            o_in_ready;
  logic [DATA_WIDTH-1:0]           i_in_result;
  logic [DATA_WIDTH-1:0]           i_in_address;
  logic [DATA_WIDTH-1:0]           i_in_result_address;
  logic [RRN_WIDTH-1:0]            i_in_rrn;
  logic                            i_in_reg_write;
  logic [CDB_COUNT-1:0]            o_bus_req;
  logic [CDB_COUNT-1:0]            i_bus_grant;
  logic [CDB_COUNT-1:0]            o_cdb_valid;
  logic [CDB_COUNT*DATA_WIDTH-1:0] o_cdb_result;
  logic [CDB_COUNT*DATA_WIDTH-1:0] o_cdb_address;
  logic [CDB_COUNT*DATA_WIDTH-1:0] o_cdb_result_address;
  logic [CDB_COUNT*RRN_WIDTH-1:0]  o_cdb_rrn;
  logic [CDB_COUNT-1:0]            o_cdb_reg_write;
  logic [DEPTH_BITS:0]             o_count;
  logic                            o_full;

  modport master (
    input  i_flush, i_in_valid, i_in_result, i_in_address, i_in_result_address,
           i_in_rrn, i_in_reg_write, i_bus_grant,
    output o_in_ready, o_bus_req, o_cdb_valid, o_cdb_result, o_cdb_address,
           o_cdb_result_address, o_cdb_rrn, o_cdb_reg_write, o_count, o_full
  );

  modport slave (
    output i_flush, i_in_valid, i_in_result, i_in_address, i_in_result_address,
           i_in_rrn, i_in_reg_write, i_bus_grant,
    input  o_in_ready, o_bus_req, o_cdb_valid, o_cdb_result, o_cdb_address,
           o_cdb_result_address, o_cdb_rrn, o_cdb_reg_write, o_count, o_full
  );
endinterface

// File: rtl/load_store_completion_buffer.sv
// FIFO of completed load/store results that broadcasts the oldest entries on
// whichever CDB channels the arbiters grant, up to CDB_COUNT per cycle.
module load_store_completion_buffer #(
  parameter int DEPTH_BITS = 2,
  parameter int CDB_COUNT  = 2,
  parameter int DATA_WIDTH = 32,
  parameter int RRN_WIDTH  = 6
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  load_store_completion_buffer_if.master bus
);
  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam int CW    = DEPTH_BITS + 1;

  logic [DATA_WIDTH-1:0] result_mem         [DEPTH];
  logic [DATA_WIDTH-1:0] address_mem        [DEPTH];
  logic [DATA_WIDTH-1:0] result_address_mem [DEPTH];
  logic [RRN_WIDTH-1:0]  rrn_mem            [DEPTH];
  logic                  reg_write_mem      [DEPTH];

  logic [DEPTH_BITS-1:0] head;
  logic [DEPTH_BITS-1:0] tail;
  logic [CW-1:0]         count;

  logic                  in_ready;
  logic                  push;
  logic [CDB_COUNT-1:0]  bus_req;
  logic [CDB_COUNT-1:0]  grant_eff;
  logic [CW-1:0]         pop_count;
  logic [DEPTH_BITS-1:0] rd_idx;

  logic [CDB_COUNT*DATA_WIDTH-1:0] cdb_result;
  logic [CDB_COUNT*DATA_WIDTH-1:0] cdb_address;
  logic [CDB_COUNT*DATA_WIDTH-1:0] cdb_result_address;
  logic [CDB_COUNT*RRN_WIDTH-1:0]  cdb_rrn;
  logic [CDB_COUNT-1:0]            cdb_reg_write;

  // Ready looks only at the registered count, so a pop in the same cycle never frees a slot early.
  assign in_ready = i_reset_n && (count < CW'(DEPTH)) && !bus.i_flush;
  assign push     = bus.i_in_valid && in_ready;

  // Channel c asks for the bus only if there is a c-th oldest entry waiting.
  always_comb begin
    bus_req = '0;
    for (int c = 0; c < CDB_COUNT; c++) begin
      bus_req[c] = (CW'(c) < count) && !bus.i_flush;
    end
  end

  // Granted channels are filled in ascending order with consecutive entries from head.
  always_comb begin
    grant_eff          = bus.i_bus_grant & bus_req;
    pop_count          = '0;
    rd_idx             = '0;
    cdb_result         = '0;
    cdb_address        = '0;
    cdb_result_address = '0;
    cdb_rrn            = '0;
    cdb_reg_write      = '0;
    for (int c = 0; c < CDB_COUNT; c++) begin
      rd_idx = head + pop_count[DEPTH_BITS-1:0];
      if (grant_eff[c]) begin
        cdb_result[c*DATA_WIDTH +: DATA_WIDTH]         = result_mem[rd_idx];
        cdb_address[c*DATA_WIDTH +: DATA_WIDTH]        = address_mem[rd_idx];
        cdb_result_address[c*DATA_WIDTH +: DATA_WIDTH] = result_address_mem[rd_idx];
        cdb_rrn[c*RRN_WIDTH +: RRN_WIDTH]              = rrn_mem[rd_idx];
        cdb_reg_write[c]                               = reg_write_mem[rd_idx];
        pop_count                                      = pop_count + CW'(1);
      end
    end
  end

  // Pointer and occupancy state; flush wins over any same-cycle push or pop.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (bus.i_flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + DEPTH_BITS'(1);
      end
      head  <= head + pop_count[DEPTH_BITS-1:0];
      count <= count + CW'(push) - pop_count;
    end
  end

  // Entry storage carries no reset; validity is tracked entirely by head/count.
  always_ff @(posedge i_clk) begin
    if (push) begin
      result_mem[tail]         <= bus.i_in_result;
      address_mem[tail]        <= bus.i_in_address;
      result_address_mem[tail] <= bus.i_in_result_address;
      rrn_mem[tail]            <= bus.i_in_rrn;
      reg_write_mem[tail]      <= bus.i_in_reg_write;
    end
  end

  assign bus.o_in_ready           = in_ready;
  assign bus.o_bus_req            = bus_req;
  assign bus.o_cdb_valid          = grant_eff;
  assign bus.o_cdb_result         = cdb_result;
  assign bus.o_cdb_address        = cdb_address;
  assign bus.o_cdb_result_address = cdb_result_address;
  assign bus.o_cdb_rrn            = cdb_rrn;
  assign bus.o_cdb_reg_write      = cdb_reg_write;
  assign bus.o_count              = count;
  assign bus.o_full               = (count == CW'(DEPTH));
endmodule

// File: tb/tb_load_store_completion_buffer.sv
// Directed bench for the load/store completion buffer with DEPTH=4 and two CDB channels.
module tb_load_store_completion_buffer;
  logic i_clk;
  logic i_reset_n;
  int   check_count;
  int   pass_count;

  load_store_completion_buffer_if #(.DEPTH_BITS(2), .CDB_COUNT(2), .DATA_WIDTH(32), .RRN_WIDTH(6)) bus ();

  load_store_completion_buffer #(.DEPTH_BITS(2), .CDB_COUNT(2), .DATA_WIDTH(32), .RRN_WIDTH(6)) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .bus       (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] res_of(input logic [5:0] rrn);
    return 32'hC0DE_0000 | {26'd0, rrn};
  endfunction

  function automatic logic [31:0] addr_of(input logic [5:0] rrn);
    return 32'h0000_1000 + {24'd0, rrn, 2'b00};
  endfunction

  function automatic logic [31:0] raddr_of(input logic [5:0] rrn);
    return 32'h8000_0100 + {26'd0, rrn};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Drives one cycle's inputs (reg_write follows rrn[0]) and lets combinational outputs settle.
  task automatic applyStimulus(input logic valid, input logic [5:0] rrn, input logic [31:0] res,
                               input logic [1:0] grant, input logic flush);
    bus.i_in_valid          = valid;
    bus.i_in_rrn            = rrn;
    bus.i_in_result         = res;
    bus.i_in_address        = addr_of(rrn);
    bus.i_in_result_address = raddr_of(rrn);
    bus.i_in_reg_write      = rrn[0];
    bus.i_bus_grant         = grant;
    bus.i_flush             = flush;
    #1;
  endtask

  task automatic tick();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic pushOne(input logic [5:0] rrn);
    applyStimulus(1'b1, rrn, res_of(rrn), 2'b00, 1'b0);
    tick();
  endtask

  initial begin
    check_count = 0;
    pass_count  = 0;
    i_reset_n   = 1'b0;
    applyStimulus(1'b0, 6'd0, 32'd0, 2'b00, 1'b0);
    repeat (2) @(negedge i_clk);

    checkOutput("reset_count", bus.o_count, 0);
    checkOutput("reset_ready", bus.o_in_ready, 0);
    checkOutput("reset_req", bus.o_bus_req, 0);
    checkOutput("reset_valid", bus.o_cdb_valid, 0);
    i_reset_n = 1'b1;
    #1;
    checkOutput("ready_after_reset", bus.o_in_ready, 1);

    // Single load: not visible on its push cycle, broadcast on the next
    applyStimulus(1'b1, 6'd5, 32'hDEAD_BEEF, 2'b01, 1'b0);
    checkOutput("t1_push_req", bus.o_bus_req, 2'b00);
    checkOutput("t1_push_valid", bus.o_cdb_valid, 2'b00);
    tick();
    applyStimulus(1'b0, 6'd0, 32'd0, 2'b01, 1'b0);
    checkOutput("t1_count", bus.o_count, 1);
    checkOutput("t1_req", bus.o_bus_req, 2'b01);
    checkOutput("t1_valid", bus.o_cdb_valid, 2'b01);
    checkOutput("t1_rrn0", bus.o_cdb_rrn[5:0], 5);
    checkOutput("t1_result0", bus.o_cdb_result[31:0], 32'hDEAD_BEEF);
    checkOutput("t1_addr0", bus.o_cdb_address[31:0], 32'h0000_1014);
    checkOutput("t1_raddr0", bus.o_cdb_result_address[31:0], 32'h8000_0105);
    checkOutput("t1_regwrite", bus.o_cdb_reg_write, 2'b01);
    checkOutput("t1_result1_zero", bus.o_cdb_result[63:32], 0);
    tick();
    checkOutput("t1_count_after", bus.o_count, 0);

    // Fill to DEPTH with no grants, then a rejected fifth push
    for (int i = 1; i <= 4; i++) pushOne(6'(i));
    checkOutput("t2_count", bus.o_count, 4);
    checkOutput("t2_full", bus.o_full, 1);
    checkOutput("t2_ready", bus.o_in_ready, 0);
    applyStimulus(1'b1, 6'd9, res_of(6'd9), 2'b00, 1'b0);
    checkOutput("t2_ready_push", bus.o_in_ready, 0);
    tick();
    checkOutput("t2_count_hold", bus.o_count, 4);

    // Flush a full buffer while grants are offered
    applyStimulus(1'b0, 6'd0, 32'd0, 2'b11, 1'b1);
    checkOutput("flush_req", bus.o_bus_req, 2'b00);
    checkOutput("flush_valid", bus.o_cdb_valid, 2'b00);
    tick();
    checkOutput("flush_count", bus.o_count, 0);
    checkOutput("flush_full", bus.o_full, 0);

    // Grant only on channel 1: oldest entry goes there
    for (int i = 1; i <= 3; i++) pushOne(6'(i));
    applyStimulus(1'b0, 6'd0, 32'd0, 2'b10, 1'b0);
    checkOutput("t3_req", bus.o_bus_req, 2'b11);
    checkOutput("t3_valid", bus.o_cdb_valid, 2'b10);
    checkOutput("t3_rrn1", bus.o_cdb_rrn[11:6], 1);
    checkOutput("t3_rrn0_zero", bus.o_cdb_rrn[5:0], 0);
    checkOutput("t3_regwrite", bus.o_cdb_reg_write, 2'b10);
    tick();
    checkOutput("t3_count", bus.o_count, 2);
    applyStimulus(1'b0, 6'd0, 32'd0, 2'b11, 1'b0);
    checkOutput("t3_valid2", bus.o_cdb_valid, 2'b11);
    checkOutput("t3_rrn0", bus.o_cdb_rrn[5:0], 2);
    checkOutput("t3_rrn1b", bus.o_cdb_rrn[11:6], 3);
    checkOutput("t3_regwrite2", bus.o_cdb_reg_write, 2'b10);
    checkOutput("t3_addr1", bus.o_cdb_address[63:32], addr_of(6'd3));
    tick();
    checkOutput("t3_count_empty", bus.o_count, 0);

    // Full: push with double grant is rejected; then push plus single grant
    for (int i = 10; i <= 13; i++) pushOne(6'(i));
    applyStimulus(1'b1, 6'd14, res_of(6'd14), 2'b11, 1'b0);
    checkOutput("t4_ready_full", bus.o_in_ready, 0);
    checkOutput("t4_rrn0", bus.o_cdb_rrn[5:0], 10);
    checkOutput("t4_rrn1", bus.o_cdb_rrn[11:6], 11);
    tick();
    checkOutput("t4_count", bus.o_count, 2);
    checkOutput("t4_ready", bus.o_in_ready, 1);
    applyStimulus(1'b1, 6'd15, res_of(6'd15), 2'b01, 1'b0);
    checkOutput("t4_valid", bus.o_cdb_valid, 2'b01);
    checkOutput("t4_rrn0b", bus.o_cdb_rrn[5:0], 12);
    tick();
    checkOutput("t4_count_same", bus.o_count, 2);
    applyStimulus(1'b0, 6'd0, 32'd0, 2'b11, 1'b0);
    checkOutput("t4_rrn0c", bus.o_cdb_rrn[5:0], 13);
    checkOutput("t4_rrn1c", bus.o_cdb_rrn[11:6], 15);
    checkOutput("t4_result1c", bus.o_cdb_result[63:32], res_of(6'd15));
    tick();
    checkOutput("t4_count_empty", bus.o_count, 0);

    // Eight pushes and eight pops across several pointer wraps
    for (int i = 20; i <= 23; i++) pushOne(6'(i));
    applyStimulus(1'b0, 6'd0, 32'd0, 2'b11, 1'b0);
    checkOutput("t5_a0", bus.o_cdb_rrn[5:0], 20);
    checkOutput("t5_a1", bus.o_cdb_rrn[11:6], 21);
    tick();
    pushOne(6'd24);
    pushOne(6'd25);
    checkOutput("t5_full", bus.o_full, 1);
    applyStimulus(1'b0, 6'd0, 32'd0, 2'b11, 1'b0);
    checkOutput("t5_b0", bus.o_cdb_rrn[5:0], 22);
    checkOutput("t5_b1", bus.o_cdb_rrn[11:6], 23);
    tick();
    applyStimulus(1'b1, 6'd26, res_of(6'd26), 2'b01, 1'b0);
    checkOutput("t5_c0", bus.o_cdb_rrn[5:0], 24);
    tick();
    applyStimulus(1'b1, 6'd27, res_of(6'd27), 2'b10, 1'b0);
    checkOutput("t5_d1", bus.o_cdb_rrn[11:6], 25);
    checkOutput("t5_d_valid", bus.o_cdb_valid, 2'b10);
    tick();
    checkOutput("t5_count", bus.o_count, 2);
    applyStimulus(1'b0, 6'd0, 32'd0, 2'b11, 1'b0);
    checkOutput("t5_e0", bus.o_cdb_rrn[5:0], 26);
    checkOutput("t5_e1", bus.o_cdb_rrn[11:6], 27);
    checkOutput("t5_e_raddr1", bus.o_cdb_result_address[63:32], raddr_of(6'd27));
    tick();
    checkOutput("t5_count_empty", bus.o_count, 0);

    // Flush with grant and push in the same cycle
    for (int i = 30; i <= 32; i++) pushOne(6'(i));
    applyStimulus(1'b1, 6'd33, res_of(6'd33), 2'b11, 1'b1);
    checkOutput("t6_req", bus.o_bus_req, 2'b00);
    checkOutput("t6_valid", bus.o_cdb_valid, 2'b00);
    checkOutput("t6_ready", bus.o_in_ready, 0);
    tick();
    checkOutput("t6_count", bus.o_count, 0);

    // Asynchronous reset mid-stream
    pushOne(6'd34);
    applyStimulus(1'b1, 6'd35, res_of(6'd35), 2'b01, 1'b0);
    checkOutput("t6_pre_rst_rrn", bus.o_cdb_rrn[5:0], 34);
    i_reset_n = 1'b0;
    #1;
    checkOutput("t6_rst_count", bus.o_count, 0);
    checkOutput("t6_rst_req", bus.o_bus_req, 2'b00);
    checkOutput("t6_rst_valid", bus.o_cdb_valid, 2'b00);
    checkOutput("t6_rst_ready", bus.o_in_ready, 0);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    applyStimulus(1'b0, 6'd0, 32'd0, 2'b01, 1'b0);
    checkOutput("t6_post_rst_req", bus.o_bus_req, 2'b00);
    pushOne(6'd36);
    applyStimulus(1'b0, 6'd0, 32'd0, 2'b01, 1'b0);
    checkOutput("t6_post_rst_rrn", bus.o_cdb_rrn[5:0], 36);
    tick();
    checkOutput("t6_final_count", bus.o_count, 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end
endmodule
